pc_adder: RTL and testbench

Program-counter incrementer for the fetch stage of the processor datapath. It combinationally produces the sequential next-instruction address from the current PC and flags address-space wrap-around. A small clocked side block records wrap events for debug and exception logic. The increment path is pure combinational logic and does not depend on clock or reset.

---
 rtl/pc_adder_pkg.sv | 9 +
 rtl/pc_adder_wrap_tracker.sv | 32 +++
 rtl/pc_adder.sv | 45 ++++
 tb/tb_pc_adder.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/pc_adder_pkg.sv
// Shared address-width and increment defaults for the fetch-stage PC incrementer.
package pc_adder_pkg;

  localparam int DEFAULT_ADDRESS_WIDTH = 11;
  localparam int DEFAULT_INCREMENT     = 1;

  typedef logic [DEFAULT_ADDRESS_WIDTH-1:0] pc_addr_t;

endpackage

// File: rtl/pc_adder_wrap_tracker.sv
// Clocked debug tracker: sticky wrap flag plus a saturating wrap-event counter.
module pc_adder_wrap_tracker #(
  parameter int WRAP_COUNT_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        carry,
  input  logic                        clr,
  output logic                        sticky,
  output logic [WRAP_COUNT_WIDTH-1:0] count
);

  function automatic logic [WRAP_COUNT_WIDTH-1:0] sat_inc(input logic [WRAP_COUNT_WIDTH-1:0] v);
    if (&v) return v;
    return v + 1'b1;
  endfunction

  // Stage p0: clear has priority over a wrap seen on the same edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sticky <= 1'b0;
      count  <= '0;
    end else if (clr) begin
      sticky <= 1'b0;
      count  <= '0;
    end else if (carry) begin
      sticky <= 1'b1;
      count  <= sat_inc(count);
    end
  end

endmodule

// File: rtl/pc_adder.sv
// Combinational PC incrementer with wrap carry; wrap tracker is built only when
// PC_ADDER_WRAP_TRACK_EN is defined, otherwise its outputs are tied low.
module pc_adder
  import pc_adder_pkg::*;
#(
  parameter int ADDRESS_WIDTH    = DEFAULT_ADDRESS_WIDTH,
  parameter int INCREMENT        = DEFAULT_INCREMENT,
  parameter int WRAP_COUNT_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ADDRESS_WIDTH-1:0]    pc_adder_in,
  output logic [ADDRESS_WIDTH-1:0]    pc_adder_out,
  output logic                        pc_adder_carry,
  input  logic                        pc_adder_wrap_clr,
  output logic                        pc_adder_wrap_sticky,
  output logic [WRAP_COUNT_WIDTH-1:0] pc_adder_wrap_count
);

  logic [ADDRESS_WIDTH:0] sum;

  // The extra sum bit is the wrap indication; no saturation on the PC path
  assign sum            = {1'b0, pc_adder_in} + (ADDRESS_WIDTH+1)'(INCREMENT);
  assign pc_adder_out   = sum[ADDRESS_WIDTH-1:0];
  assign pc_adder_carry = sum[ADDRESS_WIDTH];

`ifdef PC_ADDER_WRAP_TRACK_EN
  pc_adder_wrap_tracker #(
    .WRAP_COUNT_WIDTH(WRAP_COUNT_WIDTH)
  ) u_wrap_tracker (
    .clk   (clk),
    .reset (reset),
    .carry (pc_adder_carry),
    .clr   (pc_adder_wrap_clr),
    .sticky(pc_adder_wrap_sticky),
    .count (pc_adder_wrap_count)
  );
`else
  logic unused_tracker_inputs;
  assign unused_tracker_inputs = &{1'b0, clk, reset, pc_adder_wrap_clr};
  assign pc_adder_wrap_sticky  = 1'b0;
  assign pc_adder_wrap_count   = '0;
`endif

endmodule

// File: tb/tb_pc_adder.sv
// Directed bench for pc_adder with an arithmetic reference model; tracker
// expectations follow PC_ADDER_WRAP_TRACK_EN.
module tb_pc_adder;
  import pc_adder_pkg::*;

  localparam int AW  = 11;
  localparam int INC = 1;
  localparam int CW  = 8;
  localparam int CNT_MAX = (1 << CW) - 1;
`ifdef PC_ADDER_WRAP_TRACK_EN
  localparam bit TRACK = 1'b1;
`else
  localparam bit TRACK = 1'b0;
`endif

  logic          clk;
  logic          reset;
  pc_addr_t      pc_in;
  pc_addr_t      pc_out;
  logic          carry;
  logic          clr;
  logic          sticky;
  logic [CW-1:0] count;

  int tests;
  int fails;
  bit done;
  int m_sticky;
  int m_count;

  pc_adder #(
    .ADDRESS_WIDTH(AW),
    .INCREMENT(INC),
    .WRAP_COUNT_WIDTH(CW)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .pc_adder_in         (pc_in),
    .pc_adder_out        (pc_out),
    .pc_adder_carry      (carry),
    .pc_adder_wrap_clr   (clr),
    .pc_adder_wrap_sticky(sticky),
    .pc_adder_wrap_count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference tracker: integer event counter, capped at the counter's maximum
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_sticky <= 0;
      m_count  <= 0;
    end else if (clr) begin
      m_sticky <= 0;
      m_count  <= 0;
    end else if (int'(pc_in) + INC >= (1 << AW)) begin
      m_sticky <= 1;
      m_count  <= (m_count < CNT_MAX) ? m_count + 1 : CNT_MAX;
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (!done) begin
      int s;
      s = int'(pc_in) + INC;
      check("model_out",    32'(pc_out), 32'(s % (1 << AW)));
      check("model_carry",  32'(carry),  32'(s >= (1 << AW)));
      check("model_sticky", 32'(sticky), TRACK ? 32'(m_sticky) : 32'd0);
      check("model_count",  32'(count),  TRACK ? 32'(m_count)  : 32'd0);
    end
  end

  initial begin
    tests = 0;
    fails = 0;
    done  = 1'b0;
    reset = 1'b1;
    clr   = 1'b0;
    pc_in = '0;
    #1;
    check("reset_sticky", 32'(sticky), 32'd0);
    check("reset_count",  32'(count),  32'd0);
    check("reset_out_live", 32'(pc_out), 32'h001);
    @(negedge clk);
    reset = 1'b0;

    // Feedback chain 0 -> 1 -> 2 -> 3 -> 4 -> 5
    pc_in = 11'h000;
    #1;
    check("inc_000_out",   32'(pc_out), 32'h001);
    check("inc_000_carry", 32'(carry),  32'd0);
    for (int i = 0; i < 4; i++) begin
      #2 pc_in = pc_out;
      #1 check("chain_out", 32'(pc_out), 32'(i + 2));
    end

    @(negedge clk);
    pc_in = 11'h3FF;
    #1;
    check("inc_3ff_out",   32'(pc_out), 32'h400);
    check("inc_3ff_carry", 32'(carry),  32'd0);

    // Wrap point, with clear held so the first edge counts nothing
    @(negedge clk);
    clr   = 1'b1;
    pc_in = 11'h7FF;
    #1;
    check("inc_7ff_out",   32'(pc_out), 32'h000);
    check("inc_7ff_carry", 32'(carry),  32'd1);
    @(negedge clk);
    clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("hold3_sticky", 32'(sticky), TRACK ? 32'd1 : 32'd0);
    check("hold3_count",  32'(count),  TRACK ? 32'd3 : 32'd0);
    clr = 1'b1;
    @(negedge clk);
    check("clr_sticky", 32'(sticky), 32'd0);
    check("clr_count",  32'(count),  32'd0);
    clr   = 1'b0;

    // Saturation
    repeat (300) @(negedge clk);
    check("sat_sticky", 32'(sticky), TRACK ? 32'd1 : 32'd0);
    check("sat_count",  32'(count),  TRACK ? 32'd255 : 32'd0);

    // Clear and carry on the same edge
    clr = 1'b1;
    @(negedge clk);
    check("clr_vs_carry_sticky", 32'(sticky), 32'd0);
    check("clr_vs_carry_count",  32'(count),  32'd0);
    clr = 1'b0;

    // Build count to 5, then hit it with an asynchronous reset mid-cycle
    repeat (5) @(negedge clk);
    pc_in = 11'h010;
    check("five_count", 32'(count), TRACK ? 32'd5 : 32'd0);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("async_rst_sticky", 32'(sticky), 32'd0);
    check("async_rst_count",  32'(count),  32'd0);
    pc_in = 11'h123;
    #1;
    check("rst_out_live", 32'(pc_out), 32'h124);
    pc_in = 11'h7FF;
    #1;
    check("rst_carry_live", 32'(carry), 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("rst_hold_count", 32'(count), 32'd0);
    pc_in = 11'h000;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_count", 32'(count), 32'd0);

    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
